// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for a combinational ALU.
// Collects operand A, operand B and an opcode byte from a ready/valid byte
// stream, holds them as registered ALU inputs, captures the ALU result one
// cycle later and offers it to a ready/valid sink.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready    upstream byte stream (rx_ready out)
//   dato_a, dato_b, opcode       registered ALU operands and opcode
//   alu_result                   combinational ALU output
//   tx_data/tx_valid/tx_ready    downstream result stream (tx_ready in)
//   err_opcode                   one-cycle pulse on an unsupported opcode
module alu_operand_sequencer #(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned NB_OPCODE = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NB_DATA-1:0]   rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [NB_DATA-1:0]   dato_a,
  output logic [NB_DATA-1:0]   dato_b,
  output logic [NB_OPCODE-1:0] opcode,
  input  logic [NB_DATA-1:0]   alu_result,
  output logic [NB_DATA-1:0]   tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 err_opcode
);

  localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(8'h20);
  localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(8'h22);
  localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(8'h24);
  localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(8'h25);
  localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(8'h26);
  localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(8'h27);
  localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(8'h02);
  localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(8'h03);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_ready_q, rx_ready_d;
  logic [NB_DATA-1:0]   dato_a_q, dato_a_d;
  logic [NB_DATA-1:0]   dato_b_q, dato_b_d;
  logic [NB_OPCODE-1:0] opcode_q, opcode_d;
  logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;
  logic                 accept_c;
  logic [NB_OPCODE-1:0] op_in_c;

  // Opcodes the downstream ALU implements.
  function automatic logic is_supported(input logic [NB_OPCODE-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // rx_ready_q mirrors "in a WAIT state" but stays low while in reset.
  assign accept_c = rx_valid & rx_ready_q;
  assign op_in_c  = rx_data[NB_OPCODE-1:0];

  // Next-state and register-input logic.
  always_comb begin
    state_d  = state_q;
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    opcode_d = opcode_q;
    tx_data_d = tx_data_q;
    err_d    = 1'b0;
    case (state_q)
      WAIT_A: if (accept_c) begin
        dato_a_d = rx_data;
        state_d  = WAIT_B;
      end
      WAIT_B: if (accept_c) begin
        dato_b_d = rx_data;
        state_d  = WAIT_OP;
      end
      WAIT_OP: if (accept_c) begin
        if (is_supported(op_in_c)) begin
          opcode_d = op_in_c;
          state_d  = EXEC;
        end else begin
          err_d   = 1'b1;
          state_d = WAIT_A;
        end
      end
      EXEC: begin
        tx_data_d = alu_result;
        state_d   = SEND;
      end
      SEND: if (tx_ready) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
    // Handshake outputs are registered from the state being entered.
    rx_ready_d = (state_d == WAIT_A) || (state_d == WAIT_B) || (state_d == WAIT_OP);
    tx_valid_d = (state_d == SEND);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_A;
      rx_ready_q <= 1'b0;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      opcode_q   <= opcode_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign dato_a     = dato_a_q;
  assign dato_b     = dato_b_q;
  assign opcode     = opcode_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign err_opcode = err_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer: a driver issues operand/opcode
// byte triples and queues the expected outcome; a monitor pops and compares
// on every result transfer or error pulse.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] dato_a, dato_b, tx_data, alu_result;
  logic [5:0] opcode;
  logic       tx_valid, err_opcode;
  logic       tx_ready = 1'b0;

  bit rand_rdy = 1'b0;
  bit force_rdy = 1'b1;
  int total = 0;
  int bad = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  alu_operand_sequencer #(.NB_DATA(8), .NB_OPCODE(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .dato_a(dato_a), .dato_b(dato_b), .opcode(opcode),
    .alu_result(alu_result),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .err_opcode(err_opcode)
  );

  always #5 clk = ~clk;

  // Environment ALU fed from the DUT's registered operands.
  always_comb begin
    alu_result = 8'h00;
    case (opcode)
      6'h20: alu_result = dato_a + dato_b;
      6'h22: alu_result = dato_a - dato_b;
      6'h24: alu_result = dato_a & dato_b;
      6'h25: alu_result = dato_a | dato_b;
      6'h26: alu_result = dato_a ^ dato_b;
      6'h27: alu_result = ~(dato_a | dato_b);
      6'h02: alu_result = dato_a >> dato_b;
      6'h03: alu_result = 8'($signed(dato_a) >>> dato_b);
      default: alu_result = 8'h00;
    endcase
  end

  // Reference: expected outcome of one byte triple.
  function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] opb);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = 8'h00;
    case (opb[5:0])
      6'h20: e.data = 8'((int'(a) + int'(b)) % 256);
      6'h22: e.data = 8'((int'(a) - int'(b) + 256) % 256);
      6'h24: e.data = a & b;
      6'h25: e.data = a | b;
      6'h26: e.data = a ^ b;
      6'h27: e.data = ~(a | b);
      6'h02: e.data = (b >= 8) ? 8'h00 : 8'(int'(a) / (1 << b));
      6'h03: e.data = (b >= 8) ? {8{a[7]}} : 8'($signed(a) >>> b);
      default: e.is_err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Sink readiness changes just after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    tx_ready = rand_rdy ? 1'($urandom) : force_rdy;
  end

  // Monitor: pops the scoreboard on every transfer or error pulse.
  initial begin
    bit         prev_v = 0, prev_r = 0, prev_e = 0;
    logic [7:0] prev_d = 8'h00;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 0; prev_r = 0; prev_e = 0;
      end else begin
        if (prev_v && !prev_r) begin
          check("tx_hold_valid", 32'(tx_valid), 32'd1);
          check("tx_hold_data", 32'(tx_data), 32'(prev_d));
        end
        if (err_opcode) begin
          check("err_single_cycle", 32'(prev_e), 32'd0);
          if (sb.size() == 0) check("err_unexpected", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check("err_expected", 32'(e.is_err), 32'd1);
          end
        end
        if (tx_valid && tx_ready) begin
          if (sb.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check("tx_kind", 32'(e.is_err), 32'd0);
            check("tx_data", 32'(tx_data), 32'(e.data));
          end
        end
        prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data; prev_e = err_opcode;
      end
    end
  end

  // Offer one byte; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (rx_ready) begin
        @(posedge clk);
        ok = 1;
      end else @(negedge clk);
    end
    #1 rx_valid = 1'b0;
    if (!ok) check("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input exp_t e);
    sb.push_back(e);
    send_byte(a);
    send_byte(b);
    send_byte(op);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && rx_ready) ok = 1;
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_dato_a"}, 32'(dato_a), 32'd0);
    check({tag, "_dato_b"}, 32'(dato_b), 32'd0);
    check({tag, "_opcode"}, 32'(opcode), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_err"}, 32'(err_opcode), 32'd0);
  endtask

  function automatic exp_t mk(input bit is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    return e;
  endfunction

  initial begin
    logic [7:0] ops[8];
    logic [7:0] a, b, op;
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'h03};

    // Reset state
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rx_ready_after_reset", 32'(rx_ready), 32'd1);

    // ADD with two-cycle latency and a single-cycle valid
    force_rdy = 1'b1;
    run_txn(8'h05, 8'h03, 8'h20, mk(0, 8'h08));
    check("lat_exec_not_valid", 32'(tx_valid), 32'd0);
    check("lat_exec_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1 check("lat_send_valid", 32'(tx_valid), 32'd1);
    check("lat_send_data", 32'(tx_data), 32'h08);
    @(posedge clk);
    #1 check("valid_one_cycle", 32'(tx_valid), 32'd0);
    wait_idle();

    // SUB wrap and SRL
    run_txn(8'h03, 8'h05, 8'h22, mk(0, 8'hFE));
    wait_idle();
    run_txn(8'hF0, 8'h04, 8'h02, mk(0, 8'h0F));
    wait_idle();

    // Back-pressure: result held while sink stalls, incoming bytes ignored
    force_rdy = 1'b0;
    run_txn(8'hAA, 8'h0F, 8'h24, mk(0, 8'h0A));
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_rx_ready", 32'(rx_ready), 32'd0);
      check("stall_tx_valid", 32'(tx_valid), 32'd1);
      check("stall_tx_data", 32'(tx_data), 32'h0A);
    end
    rx_valid  = 1'b0;
    force_rdy = 1'b1;
    wait_idle();

    // Unsupported opcode: error pulse, opcode register unchanged
    run_txn(8'h11, 8'h22, 8'h21, mk(1, 8'h00));
    #1 check("err_pulse", 32'(err_opcode), 32'd1);
    check("err_opcode_kept", 32'(opcode), 32'h24);
    check("err_back_to_wait_a", 32'(rx_ready), 32'd1);
    check("err_no_valid", 32'(tx_valid), 32'd0);
    wait_idle();

    // Reset mid-sequence discards the partial operands
    send_byte(8'h07);
    send_byte(8'h09);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rx_ready_after_midreset", 32'(rx_ready), 32'd1);
    run_txn(8'h01, 8'h02, 8'h25, mk(0, 8'h03));
    wait_idle();

    // Upper opcode bits ignored
    run_txn(8'hFF, 8'h0F, 8'hE6, mk(0, 8'hF0));
    wait_idle();
    check("xor_opcode_reg", 32'(opcode), 32'h26);

    // Randomized triples with random sink readiness
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      op = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
      run_txn(a, b, op, ref_model(a, b, op));
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
